// File: rtl/spi_bus_arb.sv
// Two-requester arbiter sharing one SPI_mstr: one queued command per requester,
// round-robin grant, optional bus lock for multi-transaction sequences.
module spi_bus_arb #(
  parameter int GAP_CYCLES = 4,
  parameter int HOLD_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt0,
  input  logic        wrt1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data0,
  output logic [15:0] rd_data1,
  output logic        ovr0,
  output logic        ovr1,
  output logic        ss0_n,
  output logic        ss1_n,
  output logic        busy,
  output logic        m_wrt,
  output logic [15:0] m_cmd,
  input  logic        m_done,
  input  logic [15:0] m_rd_data,
  input  logic        m_ss_n,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      state, state_nxt;
  logic [1:0]  pend, pend_nxt, accept;
  logic [15:0] cmdq0, cmdq1, m_cmd_q;
  logic        owner, last, hold, launch, sel, xfer_end, lock_own, route;
  logic [7:0]  cnt;

  // Handshake: a wrt is taken only when that requester has nothing queued and
  // nothing in flight; its own m_done cycle counts as no longer in flight.
  assign accept[0] = wrt0 && !pend[0] && !((state == XFER) && !owner && !m_done);
  assign accept[1] = wrt1 && !pend[1] && !((state == XFER) && owner && !m_done);

  assign xfer_end  = (state == XFER) && m_done;
  assign lock_own  = owner ? lock1 : lock0;
  assign route     = (state == XFER) || (state == GAP);
  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign m_wrt     = launch;
  assign m_cmd     = launch ? (sel ? cmdq1 : cmdq0) : m_cmd_q;
  assign ss0_n     = (route && !owner) ? m_ss_n : 1'b1;
  assign ss1_n     = (route && owner) ? m_ss_n : 1'b1;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    sel       = owner;
    case (state)
      IDLE: begin
        if (|pend) begin
          launch    = 1'b1;
          sel       = (&pend) ? ~last : pend[1];
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (m_done) state_nxt = GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = hold ? HOLD : IDLE;
      end
      HOLD: begin
        // Only the locking owner may launch; the other pend waits untouched.
        if (pend[owner]) begin
          launch    = 1'b1;
          sel       = owner;
          state_nxt = XFER;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pend_nxt = pend | accept;
    if (launch) pend_nxt[sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 2'b00;
      cmdq0    <= '0;
      cmdq1    <= '0;
      m_cmd_q  <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      hold     <= 1'b0;
      cnt      <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rd_data0 <= '0;
      rd_data1 <= '0;
      ovr0     <= 1'b0;
      ovr1     <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (accept[0]) cmdq0 <= cmd0;
      if (accept[1]) cmdq1 <= cmd1;
      if (launch) begin
        owner   <= sel;
        m_cmd_q <= m_cmd;
      end
      // Counter restarts on every state change, so GAP and HOLD each count from 0.
      cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      done0 <= xfer_end && !owner;
      done1 <= xfer_end && owner;
      if (xfer_end) begin
        if (owner) rd_data1 <= m_rd_data;
        else       rd_data0 <= m_rd_data;
        hold <= lock_own;
        last <= owner;
      end else if ((state == HOLD) && (state_nxt == IDLE)) begin
        hold <= 1'b0;
      end
      ovr0 <= wrt0 && !accept[0];
      ovr1 <= wrt1 && !accept[1];
    end
  end

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of pend/grant/gap rules.
module tb_spi_bus_arb;

  localparam int GAP  = 4;
  localparam int HOLD = 64;

  logic        clk, rst_n;
  logic        wrt0, wrt1, lock0, lock1;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1, ovr0, ovr1, ss0_n, ss1_n, busy, m_wrt;
  logic [15:0] rd_data0, rd_data1, m_cmd;
  logic        m_done, m_ss_n;
  logic [15:0] m_rd_data;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spi_bus_arb #(.GAP_CYCLES(GAP), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .wrt0(wrt0), .wrt1(wrt1), .cmd0(cmd0), .cmd1(cmd1),
    .lock0(lock0), .lock1(lock1),
    .done0(done0), .done1(done1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .ovr0(ovr0), .ovr1(ovr1), .ss0_n(ss0_n), .ss1_n(ss1_n), .busy(busy),
    .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data),
    .m_ss_n(m_ss_n), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wrt0 = 0; wrt1 = 0; lock0 = 0; lock1 = 0; cmd0 = 0; cmd1 = 0;
    m_done = 0; m_ss_n = 1; m_rd_data = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // driver helpers
  task automatic wait_launch(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_wrt) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (m_wrt !== 1'b1) begin
      failures++;
      $display("FAIL launch_timeout: m_wrt=%b required 1 within 200 cycles", m_wrt);
    end
  endtask

  // Called at the negedge of the launch cycle; returns k = m_done cycle, positioned in k+1.
  task automatic run_xfer(input int lat, input logic [15:0] rd, input logic l0, input logic l1,
                          output int k);
    step();
    wrt0 = 0; wrt1 = 0; m_ss_n = 0;
    repeat (lat - 1) step();
    m_done = 1; m_rd_data = rd; lock0 = l0; lock1 = l1;
    k = cyc;
    step();
    m_done = 0; lock0 = 0; lock1 = 0; m_ss_n = 1;
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    step();
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (m_wrt !== 1'b0) begin failures++; $display("FAIL reset_m_wrt got=%b exp=0", m_wrt); end
    checks++; if (m_cmd !== 16'h0) begin failures++; $display("FAIL reset_m_cmd got=%h exp=0000", m_cmd); end
    checks++; if ({done0, done1} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {done0, done1}); end
    checks++; if ({rd_data0, rd_data1} !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", {rd_data0, rd_data1}); end
    checks++; if ({ovr0, ovr1} !== 2'b00) begin failures++; $display("FAIL reset_ovr got=%b exp=00", {ovr0, ovr1}); end
    checks++; if ({ss0_n, ss1_n} !== 2'b11) begin failures++; $display("FAIL reset_ss got=%b exp=11", {ss0_n, ss1_n}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    step();
  endtask

  task automatic test_single();
    int n, at;
    cmd0 = 16'h1800; wrt0 = 1; n = cyc;
    step();
    wrt0 = 0;
    wait_launch(at);
    checks++; if (at !== n + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", at - n, 1); end
    checks++; if (m_cmd !== 16'h1800) begin failures++; $display("FAIL single_cmd got=%h exp=1800", m_cmd); end
    for (int i = 0; i < 40; i++) begin
      step();
      m_ss_n = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 39) begin m_done = 1; m_rd_data = 16'h0ABC; end
      @(negedge clk);
      checks++; if (ss0_n !== m_ss_n) begin failures++; $display("FAIL single_ss0 got=%b exp=%b", ss0_n, m_ss_n); end
      checks++; if (ss1_n !== 1'b1) begin failures++; $display("FAIL single_ss1 got=%b exp=1", ss1_n); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", done0); end
    end
    step();
    m_done = 0; m_ss_n = 1;
    @(negedge clk);
    checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL single_done0 got=%b exp=1", done0); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL single_done1 got=%b exp=0", done1); end
    checks++; if (rd_data0 !== 16'h0ABC) begin failures++; $display("FAIL single_rd_data0 got=%h exp=0abc", rd_data0); end
    step();
    @(negedge clk);
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done0); end
    idle_wait();
  endtask

  task automatic test_round_robin();
    int at, k;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cmd0 = 16'hA000 + 16'(pass); cmd1 = 16'hB000 + 16'(pass);
      wrt0 = 1; wrt1 = 1;
      step();
      wrt0 = 0; wrt1 = 0;
      wait_launch(at);
      checks++; if (m_cmd !== 16'hA000 + 16'(pass)) begin failures++; $display("FAIL rr_first_grant pass%0d got=%h exp=%h", pass, m_cmd, 16'hA000 + 16'(pass)); end
      run_xfer(8, 16'h1111, 0, 0, k);
      @(negedge clk);
      checks++; if (done0 !== 1'b1 || rd_data0 !== 16'h1111) begin failures++; $display("FAIL rr_done0 got=%b/%h exp=1/1111", done0, rd_data0); end
      wait_launch(at);
      checks++; if (at - k !== GAP + 1) begin failures++; $display("FAIL rr_gap got=%0d exp=%0d", at - k, GAP + 1); end
      checks++; if (m_cmd !== 16'hB000 + 16'(pass)) begin failures++; $display("FAIL rr_second_grant got=%h exp=%h", m_cmd, 16'hB000 + 16'(pass)); end
      run_xfer(5, 16'h2222, 0, 0, k);
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || rd_data1 !== 16'h2222) begin failures++; $display("FAIL rr_done1 got=%b/%h exp=1/2222", done1, rd_data1); end
      idle_wait();
    end
  endtask

  task automatic test_lock();
    int at, k, k2;
    logic saw;
    do_reset();
    cmd0 = 16'hC001; wrt0 = 1;
    step();
    wrt0 = 0;
    wait_launch(at);
    cmd1 = 16'hD001; wrt1 = 1;
    run_xfer(6, 16'h3333, 1, 0, k);
    saw = 0;
    while (cyc < k + GAP + 11) begin
      @(negedge clk);
      if (m_wrt) saw = 1;
      step();
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL lock_hold_blocks got=%b exp=0", saw); end
    cmd0 = 16'hC002; wrt0 = 1;
    step();
    wrt0 = 0;
    wait_launch(at);
    checks++; if (at !== k + GAP + 12) begin failures++; $display("FAIL lock_relaunch_time got=%0d exp=%0d", at - k, GAP + 12); end
    checks++; if (m_cmd !== 16'hC002) begin failures++; $display("FAIL lock_owner_first got=%h exp=c002", m_cmd); end
    run_xfer(4, 16'h4444, 0, 0, k2);
    @(negedge clk);
    checks++; if (done0 !== 1'b1 || rd_data0 !== 16'h4444) begin failures++; $display("FAIL lock_done0 got=%b/%h exp=1/4444", done0, rd_data0); end
    wait_launch(at);
    checks++; if (m_cmd !== 16'hD001 || at - k2 !== GAP + 1) begin failures++; $display("FAIL lock_then_req1 got=%h@%0d exp=d001@%0d", m_cmd, at - k2, GAP + 1); end
    run_xfer(3, 16'h5555, 0, 0, k);
    idle_wait();
  endtask

  task automatic test_hold_timeout();
    int at, k;
    do_reset();
    cmd0 = 16'hE001; wrt0 = 1;
    step();
    wrt0 = 0;
    wait_launch(at);
    cmd1 = 16'hF001; wrt1 = 1;
    run_xfer(5, 16'h6666, 1, 0, k);
    wait_launch(at);
    checks++; if (at - k !== GAP + HOLD + 1) begin failures++; $display("FAIL hold_timeout_time got=%0d exp=%0d", at - k, GAP + HOLD + 1); end
    checks++; if (m_cmd !== 16'hF001) begin failures++; $display("FAIL hold_timeout_cmd got=%h exp=f001", m_cmd); end
    run_xfer(2, 16'h7777, 0, 0, k);
    idle_wait();
  endtask

  task automatic test_overrun();
    int at, k;
    do_reset();
    cmd0 = 16'h0101; wrt0 = 1;
    step();
    wrt0 = 0;
    wait_launch(at);
    step();
    cmd1 = 16'h1234; wrt1 = 1;
    step();
    wrt1 = 0;
    @(negedge clk);
    checks++; if (ovr1 !== 1'b0) begin failures++; $display("FAIL ovr_first_accepted got=%b exp=0", ovr1); end
    step();
    cmd1 = 16'h5678; wrt1 = 1;
    step();
    wrt1 = 0;
    @(negedge clk);
    checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", ovr1); end
    checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL ovr_other got=%b exp=0", ovr0); end
    step();
    @(negedge clk);
    checks++; if (ovr1 !== 1'b0) begin failures++; $display("FAIL ovr_single_pulse got=%b exp=0", ovr1); end
    step();
    m_done = 1; m_rd_data = 16'h9999;
    step();
    m_done = 0;
    wait_launch(at);
    checks++; if (m_cmd !== 16'h1234) begin failures++; $display("FAIL ovr_keeps_first got=%h exp=1234", m_cmd); end
    run_xfer(2, 16'h8888, 0, 0, k);
    idle_wait();
  endtask

  task automatic test_reset_mid();
    int at;
    do_reset();
    cmd1 = 16'h4321; wrt1 = 1;
    step();
    wrt1 = 0;
    wait_launch(at);
    step();
    m_ss_n = 0;
    repeat (3) step();
    rst_n = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL rstmid_busy got=%b/%0d exp=0/0", busy, fsm_state); end
    checks++; if (ss1_n !== 1'b1 || ss0_n !== 1'b1) begin failures++; $display("FAIL rstmid_ss got=%b%b exp=11", ss0_n, ss1_n); end
    checks++; if (m_cmd !== 16'h0 || m_wrt !== 1'b0) begin failures++; $display("FAIL rstmid_m got=%h/%b exp=0000/0", m_cmd, m_wrt); end
    step();
    rst_n = 1; m_done = 1; m_rd_data = 16'hDEAD;
    step();
    m_done = 0; m_ss_n = 1;
    @(negedge clk);
    checks++; if (done1 !== 1'b0 || rd_data1 !== 16'h0) begin failures++; $display("FAIL rstmid_no_done got=%b/%h exp=0/0000", done1, rd_data1); end
    checks++; if (m_wrt !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_relaunch got=%b/%b exp=0/0", m_wrt, busy); end
    step();
  endtask

  // Transaction-level model: queued commands, round-robin pick, free time after GAP.
  task automatic test_random();
    logic        mp [2];
    logic [15:0] mc [2];
    logic        e_done [2], e_ovr [2], acc [2], w [2];
    logic [15:0] e_rd [2], c [2];
    logic [15:0] last_cmd, e_cmd;
    logic        mlast, infl, own, md, exp_wrt, sel, in_gap, e_ss, a_ss, a_done, a_ovr;
    logic [15:0] a_rd;
    int          free_at, left;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mc[i] = 0; e_done[i] = 0; e_ovr[i] = 0; e_rd[i] = 0;
    end
    last_cmd = 0; mlast = 1; infl = 0; own = 0; free_at = 0; left = 0; sel = 0;
    for (int n = 0; n < 1500; n++) begin
      w[0] = ($urandom_range(0, 5) == 0);
      w[1] = ($urandom_range(0, 5) == 0);
      c[0] = 16'($urandom); c[1] = 16'($urandom);
      md = infl ? (left == 0) : ($urandom_range(0, 7) == 0);
      wrt0 = w[0]; wrt1 = w[1]; cmd0 = c[0]; cmd1 = c[1];
      m_done = md; m_rd_data = 16'($urandom); m_ss_n = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_wrt = !infl && (cyc >= free_at) && (mp[0] || mp[1]);
      if (exp_wrt) sel = (mp[0] && mp[1]) ? !mlast : mp[1];
      e_cmd = exp_wrt ? mc[sel] : last_cmd;
      in_gap = !infl && (cyc < free_at);
      checks++; if (m_wrt !== exp_wrt) begin failures++; $display("FAIL rand_m_wrt cyc%0d got=%b exp=%b", cyc, m_wrt, exp_wrt); end
      checks++; if (m_cmd !== e_cmd) begin failures++; $display("FAIL rand_m_cmd cyc%0d got=%h exp=%h", cyc, m_cmd, e_cmd); end
      for (int i = 0; i < 2; i++) begin
        a_done = (i == 0) ? done0 : done1;
        a_rd   = (i == 0) ? rd_data0 : rd_data1;
        a_ovr  = (i == 0) ? ovr0 : ovr1;
        a_ss   = (i == 0) ? ss0_n : ss1_n;
        e_ss   = ((infl || in_gap) && (own == 1'(i))) ? m_ss_n : 1'b1;
        checks++; if (a_done !== e_done[i]) begin failures++; $display("FAIL rand_done%0d cyc%0d got=%b exp=%b", i, cyc, a_done, e_done[i]); end
        checks++; if (a_rd !== e_rd[i]) begin failures++; $display("FAIL rand_rd_data%0d cyc%0d got=%h exp=%h", i, cyc, a_rd, e_rd[i]); end
        checks++; if (a_ovr !== e_ovr[i]) begin failures++; $display("FAIL rand_ovr%0d cyc%0d got=%b exp=%b", i, cyc, a_ovr, e_ovr[i]); end
        checks++; if (a_ss !== e_ss) begin failures++; $display("FAIL rand_ss%0d cyc%0d got=%b exp=%b", i, cyc, a_ss, e_ss); end
      end
      for (int i = 0; i < 2; i++) begin
        acc[i]    = w[i] && !mp[i] && !(infl && (own == 1'(i)) && !md);
        e_ovr[i]  = w[i] && !acc[i];
        e_done[i] = 0;
      end
      if (infl && md) begin
        e_done[own] = 1; e_rd[own] = m_rd_data; mlast = own; infl = 0;
        free_at = cyc + GAP + 1;
      end else if (infl) begin
        left--;
      end
      if (exp_wrt) begin
        mp[sel] = 0; own = sel; infl = 1; left = $urandom_range(0, 10); last_cmd = mc[sel];
      end
      for (int i = 0; i < 2; i++) if (acc[i]) begin mp[i] = 1; mc[i] = c[i]; end
      step();
    end
    wrt0 = 0; wrt1 = 0; m_done = 0; m_ss_n = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_hold_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_bus_arb.md
# spi_bus_arb

Two-requester arbiter that shares one `SPI_mstr` instance between the A2D interface (requester 0) and a second SPI client (requester 1, e.g. inertial sensor). It queues one command per requester, grants the bus round-robin, and launches each queued command as a single `SPI_mstr` transaction. It routes SPI_mstr's `SS_n` only to the granted slave and returns `done`/`rd_data` to the owner. A lock mechanism keeps the bus for multi-transaction sequences such as the A2D request/receive pair.

## Interface
- GAP_CYCLES, 4: idle clocks between end of one transaction and the next launch; range 1–15.
- HOLD_MAX, 64: max clocks the bus stays reserved for a locking owner after GAP; range 1–255.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- wrt0 / wrt1  in  1  one-cycle command request from requester 0 / 1
- cmd0 / cmd1  in  16  command word, sampled with the matching wrt
- lock0 / lock1  in  1  sampled at transaction end; high reserves the bus for the owner's next command
- done0 / done1  out  1  one-cycle completion pulse to the owner
- rd_data0 / rd_data1  out  16  last read data for that requester; held until its next done
- ovr0 / ovr1  out  1  one-cycle pulse when a wrt is dropped
- ss0_n / ss1_n  out  1  per-slave select
- busy  out  1  high whenever state ≠ IDLE
- m_wrt  out  1  launch pulse to SPI_mstr
- m_cmd  out  16  command to SPI_mstr
- m_done  in  1  SPI_mstr completion
- m_rd_data  in  16  SPI_mstr read data
- m_ss_n  in  1  SPI_mstr SS_n

## Operation
- Per requester i there is a pending flag `pend_i` and a 16-bit command register `cmdq_i`.
  - `wrt_i` with `pend_i`=0 and i not in flight: set `pend_i`, capture `cmd_i`.
  - Otherwise the wrt is dropped and `ovr_i` pulses.
  - A `wrt_i` in the same cycle as i's `m_done` is accepted.
- Round-robin: a 1-bit `last` records the most recently served requester (reset 1, so requester 0 wins first). With both pending, the grant goes to `!last`; with one pending, that one is granted.
- States:
  - IDLE: if any eligible pend, select owner, pulse `m_wrt`, drive `m_cmd`=`cmdq_owner`, clear `pend_owner`, go to XFER.
  - XFER: wait for `m_done`. Then:
    - register `m_rd_data` into `rd_data_owner`;
    - pulse `done_owner` the next cycle;
    - sample `lock_owner` into `hold`;
    - set `last`=owner;
    - go to GAP.
  - GAP: count GAP_CYCLES. Then go to HOLD if `hold`, else IDLE.
  - HOLD: only the owner is eligible. If `pend_owner`, launch as in IDLE and go to XFER. Otherwise count; after HOLD_MAX cycles clear `hold` and go to IDLE. The other requester's pend stays queued and is not dropped.
- Select routing: `ssi_n` = `m_ss_n` when i is owner and state ∈ {XFER, GAP}, else 1.
- `m_cmd` holds the last launched command between launches.

## Timing
- Reset values: `m_wrt`=0, `m_cmd`=0, `done_i`=0, `rd_data_i`=0, `ovr_i`=0, `ssi_n`=1, `busy`=0. Internal: pend=0, hold=0, state=IDLE, `last`=1.
- Launch latency: `wrt_i` high in cycle n → `pend_i` high in n+1 → `m_wrt` high in n+1 (combinational from IDLE & pend) → XFER from n+2.
- Completion: `m_done` in cycle k → `done_i` and new `rd_data_i` in k+1 → GAP for cycles k+1 … k+GAP_CYCLES → earliest next `m_wrt` in cycle k+GAP_CYCLES+1.
- `m_wrt` is never high outside IDLE/HOLD, and never more than once per transaction.
- `m_done` outside XFER is ignored.
- `ovr_i` pulses in the cycle after the offending wrt.
- Reset asserted mid-transfer returns all state and outputs to reset values immediately. SPI_mstr shares `rst_n`.

## Test plan
- Single request: `wrt0` with cmd0=16'h1800, `m_done` after 40 cycles with `m_rd_data`=16'h0ABC → `m_wrt` one cycle later with `m_cmd`=16'h1800, `ss0_n` follows `m_ss_n`, `ss1_n`=1, `done0` one cycle after `m_done`, `rd_data0`=16'h0ABC.
- Simultaneous `wrt0`/`wrt1` out of reset → requester 0 served first. Requester 1 launches exactly GAP_CYCLES+1 cycles after requester 0's `m_done`. On the next simultaneous pair, requester 0 is granted, because `last`=1 after serving requester 1.
- Lock sequence: requester 0 holds `lock0`=1 at `m_done`, requester 1 pending, `wrt0` arrives 10 cycles into HOLD → requester 0 launches before requester 1. Requester 1 is then served after requester 0's second transaction.
- Hold timeout: `lock0`=1, no further `wrt0`, `wrt1` pending → requester 1 launches in the cycle after HOLD_MAX cycles in HOLD.
- Overrun: two `wrt1` pulses while requester 1 is pending → second pulse produces one `ovr1` pulse, and `cmdq1` keeps the first command.
- Reset mid-XFER → all outputs at reset values next cycle, and no `done_i` is produced.
